// File: rtl/lcis_pkg.sv
// lcis_pkg: shared FSM state enum and order_mode encodings for the LCIS engine
package lcis_pkg;
  typedef enum logic [2:0] {IDLE, READ, SCAN, WR_LEN, WR_IDX, DONE} state_t;
  localparam logic [1:0] MODE_INC_S  = 2'd0;
  localparam logic [1:0] MODE_NDEC_S = 2'd1;
  localparam logic [1:0] MODE_DEC_S  = 2'd2;
  localparam logic [1:0] MODE_INC_U  = 2'd3;
endpackage

// File: rtl/lcis_if.sv
// lcis_if: order command bus; master drives order_valid/start/len/back/mode, slave returns order_busy/order_done
interface lcis_if #(parameter int ADDR_WIDTH = 16);
  logic                  order_valid;
  logic [ADDR_WIDTH-1:0] order_start;
  logic [ADDR_WIDTH-1:0] order_len;
  logic [ADDR_WIDTH-1:0] order_back;
  logic [1:0]            order_mode;
  logic                  order_busy;
  logic                  order_done;
  modport master (output order_valid, order_start, order_len, order_back, order_mode, input order_busy, order_done);
  modport slave (input order_valid, order_start, order_len, order_back, order_mode, output order_busy, order_done);
endinterface

// File: rtl/lcis_ram.sv
// lcis_ram: synchronous 1R/1W RAM, 1-cycle read latency; ports clk, i_rd_en/i_rd_addr/o_rd_data, i_we/i_wr_addr/i_wr_data
module lcis_ram #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data
);
  logic [DATA_WIDTH-1:0] memory [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) memory[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= memory[i_rd_addr];
  end
endmodule

// File: rtl/lcis_engine.sv
// lcis_engine: finds the longest monotonic run in RAM[start..start+len-1] and writes its length/start to RAM[back], RAM[back+1]; ports clk, rst, bus (lcis_if.slave)
module lcis_engine
  import lcis_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input logic   clk,
  input logic   rst,
  lcis_if.slave bus
);
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_start, r_len, r_back, r_idx, r_run, r_rstart, r_best, r_bstart;
  logic [1:0] r_mode;
  logic [DATA_WIDTH-1:0] r_prev, w_rd_data, w_wr_data;
  logic [ADDR_WIDTH-1:0] w_cur, w_rd_addr, w_wr_addr, w_run, w_rstart;
  logic w_accept, w_proc, w_cond, w_ext, w_rd_en, w_we;
  lcis_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data),
    .i_we      (w_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data)
  );
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE, DONE: w_next = w_accept ? READ : IDLE;
      READ:       w_next = SCAN;
      SCAN:       w_next = w_proc ? SCAN : WR_LEN;
      WR_LEN:     w_next = WR_IDX;
      WR_IDX:     w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end
  // Read data lags its address by one cycle, so SCAN spends len cycles consuming
  // elements plus one final cycle, giving len+4 cycles from accept to DONE.
  always_comb begin
    bus.order_busy = r_state inside {READ, SCAN, WR_LEN, WR_IDX};
    bus.order_done = r_state == DONE;
    w_accept  = bus.order_valid && !bus.order_busy;
    w_proc    = r_idx != r_len;
    w_cur     = r_start + r_idx;
    w_rd_en   = (r_state == READ && r_len != '0) || (r_state == SCAN && w_proc && r_idx + ADDR_WIDTH'(1) != r_len);
    w_rd_addr = r_state == READ ? r_start : w_cur + ADDR_WIDTH'(1);
    w_we      = (r_state == WR_LEN || r_state == WR_IDX) && !rst;
    w_wr_addr = r_state == WR_IDX ? r_back + ADDR_WIDTH'(1) : r_back;
    w_wr_data = r_state == WR_IDX ? DATA_WIDTH'(r_bstart) : DATA_WIDTH'(r_best);
  end
  always_comb begin
    w_cond   = r_mode == MODE_INC_U  ? r_prev < w_rd_data :
               r_mode == MODE_DEC_S  ? $signed(r_prev) >  $signed(w_rd_data) :
               r_mode == MODE_NDEC_S ? $signed(r_prev) <= $signed(w_rd_data) :
                                       $signed(r_prev) <  $signed(w_rd_data);
    w_ext    = r_idx != '0 && w_cond;
    w_run    = w_ext ? r_run + ADDR_WIDTH'(1) : ADDR_WIDTH'(1);
    w_rstart = w_ext ? r_rstart : w_cur;
  end
  // Best defaults to (0, start) so a zero-length order reports that pair untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start  <= '0;
      r_len    <= '0;
      r_back   <= '0;
      r_mode   <= '0;
      r_idx    <= '0;
      r_run    <= '0;
      r_rstart <= '0;
      r_best   <= '0;
      r_bstart <= '0;
      r_prev   <= '0;
    end else if (w_accept) begin
      r_start  <= bus.order_start;
      r_len    <= bus.order_len;
      r_back   <= bus.order_back;
      r_mode   <= bus.order_mode;
      r_idx    <= '0;
      r_run    <= '0;
      r_rstart <= bus.order_start;
      r_best   <= '0;
      r_bstart <= bus.order_start;
    end else if (r_state == SCAN && w_proc) begin
      r_idx    <= r_idx + ADDR_WIDTH'(1);
      r_run    <= w_run;
      r_rstart <= w_rstart;
      r_prev   <= w_rd_data;
      if (w_run > r_best) begin
        r_best   <= w_run;
        r_bstart <= w_rstart;
      end
    end
  end
endmodule
